// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit frame controller: sequences an external 8-bit LSB-first serializer
// and muxes start, data, optional parity and stop bits onto the TX line.
`timescale 1ns/1ps
module uart_tx_frame_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] p_data,
  input  logic       data_valid,
  input  logic       par_en,
  input  logic       par_typ,
  input  logic       ser_data,
  input  logic       ser_done,
  output logic [7:0] ser_p_data,
  output logic       load,
  output logic       ser_en,
  output logic       tx_out,
  output logic       busy,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t state;
  logic   par_en_q;
  logic   par_typ_q;
  logic   parity_bit;

  // Handshake: data_valid is a request with an implicit ready of !busy; a request
  // is taken on a clock edge in IDLE only, anything presented while busy is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      ser_p_data <= 8'h00;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      load       <= 1'b0;
      ser_en     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (data_valid) begin
            ser_p_data <= p_data;
            par_en_q   <= par_en;
            par_typ_q  <= par_typ;
            load       <= 1'b1;
            busy       <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          load   <= 1'b0;
          ser_en <= 1'b1;
          state  <= DATA;
        end
        DATA: begin
          if (ser_done) begin
            ser_en <= 1'b0;
            state  <= par_en_q ? PARITY : STOP;
          end
        end
        PARITY: begin
          state <= STOP;
        end
        STOP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          load   <= 1'b0;
          ser_en <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  // Parity comes from the latched byte so live p_data cannot disturb a frame.
  assign parity_bit = (^ser_p_data) ^ par_typ_q;

  always_comb begin
    tx_out = 1'b1;
    case (state)
      START:   tx_out = 1'b0;
      DATA:    tx_out = ser_data;
      PARITY:  tx_out = parity_bit;
      default: tx_out = 1'b1;
    endcase
  end

  assign state_dbg = state;

endmodule
